// File: rtl/if_fetch_stage.sv
// Fetch stage and IF/ID register for the 5-stage MIPS core, with a req/ready instruction-memory port.
// Optional performance counters (BubbleCnt, KillCnt) are enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] BubbleCnt,
    output logic [31:0] KillCnt,
`endif
    output logic        ImemBusyF
);

    typedef enum logic [1:0] {BOOT, FETCH, KILL, HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pcf, pcf_nx;
    logic [31:0] pend_pc, pend_pc_nx;
    logic [31:0] hold_instr, hold_instr_nx;
    logic [31:0] hold_pc4, hold_pc4_nx;
    logic [31:0] instr_nx, pc4_nx;
    logic        valid_nx;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Branch operands are only trustworthy once D is not stalled.
    assign redirect = PCSrcD & ~StallD;
    assign target   = {PCBranchD[31:2], 2'b00};
    assign pc_plus4 = pcf + 32'd4;

    assign imem_req  = (state == FETCH) || (state == KILL);
    assign imem_addr = pcf;
    assign ImemBusyF = imem_req & ~imem_ready;

    always_comb begin
        state_nx      = state;
        pcf_nx        = pcf;
        pend_pc_nx    = pend_pc;
        hold_instr_nx = hold_instr;
        hold_pc4_nx   = hold_pc4;
        instr_nx      = InstrD;
        pc4_nx        = PCPlus4D;
        valid_nx      = ValidD;
        case (state)
            BOOT: state_nx = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pcf_nx   = target;
                        valid_nx = 1'b0;
                        instr_nx = NOP_INSTR;
                    end else if (StallF || StallD) begin
                        hold_instr_nx = imem_rdata;
                        hold_pc4_nx   = pc_plus4;
                        pcf_nx        = pc_plus4;
                        state_nx      = HOLD;
                    end else begin
                        instr_nx = imem_rdata;
                        pc4_nx   = pc_plus4;
                        valid_nx = 1'b1;
                        pcf_nx   = pc_plus4;
                    end
                end else if (redirect) begin
                    // The in-flight request cannot be withdrawn; remember where to go once it lands.
                    pend_pc_nx = target;
                    valid_nx   = 1'b0;
                    instr_nx   = NOP_INSTR;
                    state_nx   = KILL;
                end else if (!StallD) begin
                    valid_nx = 1'b0;
                    instr_nx = NOP_INSTR;
                end
            end
            KILL: begin
                if (redirect) pend_pc_nx = target;
                if (imem_ready) begin
                    pcf_nx   = redirect ? target : pend_pc;
                    state_nx = FETCH;
                end
                if (!StallD) begin
                    valid_nx = 1'b0;
                    instr_nx = NOP_INSTR;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pcf_nx   = target;
                    valid_nx = 1'b0;
                    instr_nx = NOP_INSTR;
                    state_nx = FETCH;
                end else if (!StallD && !StallF) begin
                    instr_nx = hold_instr;
                    pc4_nx   = hold_pc4;
                    valid_nx = 1'b1;
                    state_nx = FETCH;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pcf        <= RESET_PC;
            pend_pc    <= 32'd0;
            hold_instr <= 32'd0;
            hold_pc4   <= 32'd0;
            InstrD     <= NOP_INSTR;
            PCPlus4D   <= 32'd0;
            ValidD     <= 1'b0;
        end else begin
            state      <= state_nx;
            pcf        <= pcf_nx;
            pend_pc    <= pend_pc_nx;
            hold_instr <= hold_instr_nx;
            hold_pc4   <= hold_pc4_nx;
            InstrD     <= instr_nx;
            PCPlus4D   <= pc4_nx;
            ValidD     <= valid_nx;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic bubble_evt, kill_evt;

    // Only starvation bubbles count; flush bubbles are accounted for by KillCnt.
    assign bubble_evt = (state == FETCH) && !imem_ready && !redirect && !StallD;
    assign kill_evt   = ((state == FETCH) && imem_ready && redirect) ||
                        ((state == KILL) && imem_ready) ||
                        ((state == HOLD) && redirect);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BubbleCnt <= 32'd0;
            KillCnt   <= 32'd0;
        end else begin
            if (bubble_evt) BubbleCnt <= BubbleCnt + 32'd1;
            if (kill_evt)   KillCnt   <= KillCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk, rst;
    logic        StallF, StallD, PCSrcD;
    logic [31:0] PCBranchD;
    logic        imem_req, imem_ready, ValidD, ImemBusyF;
    logic [31:0] imem_addr, imem_rdata, InstrD, PCPlus4D;
`ifdef IF_PERF_CNT_EN
    logic [31:0] BubbleCnt, KillCnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic busy_pre;

    if_fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrD(InstrD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD),
`ifdef IF_PERF_CNT_EN
        .BubbleCnt(BubbleCnt), .KillCnt(KillCnt),
`endif
        .ImemBusyF(ImemBusyF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: tracks "booting", "holding a word" and "waiting to discard" as flags.
    logic        m_boot, m_hold, m_kill, m_valid;
    logic [31:0] m_pc, m_ktgt, m_hw, m_hpc4, m_instr, m_pc4, m_bub, m_kcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_boot <= 1; m_hold <= 0; m_kill <= 0; m_valid <= 0;
            m_pc <= RPC; m_ktgt <= 0; m_hw <= 0; m_hpc4 <= 0;
            m_instr <= NOP; m_pc4 <= 0; m_bub <= 0; m_kcnt <= 0;
        end else begin
            logic redir;
            logic [31:0] tgt, kt;
            redir = PCSrcD && !StallD;
            tgt   = PCBranchD & 32'hFFFF_FFFC;
            if (m_boot) begin
                m_boot <= 0;
            end else if (m_hold) begin
                if (redir) begin
                    m_hold <= 0; m_pc <= tgt; m_valid <= 0; m_instr <= NOP; m_kcnt <= m_kcnt + 1;
                end else if (!StallD && !StallF) begin
                    m_hold <= 0; m_instr <= m_hw; m_pc4 <= m_hpc4; m_valid <= 1;
                end
            end else if (m_kill) begin
                kt = redir ? tgt : m_ktgt;
                m_ktgt <= kt;
                if (imem_ready) begin
                    m_pc <= kt; m_kill <= 0; m_kcnt <= m_kcnt + 1;
                end
                if (!StallD) begin
                    m_valid <= 0; m_instr <= NOP;
                end
            end else if (imem_ready) begin
                if (redir) begin
                    m_pc <= tgt; m_valid <= 0; m_instr <= NOP; m_kcnt <= m_kcnt + 1;
                end else if (StallF || StallD) begin
                    m_hold <= 1; m_hw <= imem_rdata; m_hpc4 <= m_pc + 4; m_pc <= m_pc + 4;
                end else begin
                    m_instr <= imem_rdata; m_pc4 <= m_pc + 4; m_valid <= 1; m_pc <= m_pc + 4;
                end
            end else if (redir) begin
                m_kill <= 1; m_ktgt <= tgt; m_valid <= 0; m_instr <= NOP;
            end else if (!StallD) begin
                m_valid <= 0; m_instr <= NOP; m_bub <= m_bub + 1;
            end
        end
    end

    task automatic cyc(input logic rdy, input logic sf, input logic sd, input logic br,
                       input logic [31:0] t, input logic [31:0] w);
        imem_ready = rdy; StallF = sf; StallD = sd; PCSrcD = br; PCBranchD = t; imem_rdata = w;
        #1 busy_pre = ImemBusyF;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; imem_ready = 0; StallF = 0; StallD = 0; PCSrcD = 0; PCBranchD = 0; imem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (imem_req !== 1'b0 || ValidD !== 1'b0 || ImemBusyF !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl got req=%b valid=%b busy=%b want 0 0 0", imem_req, ValidD, ImemBusyF);
        end
        n_cmp++; if (InstrD !== NOP || PCPlus4D !== 32'd0 || imem_addr !== RPC) begin
            n_err++; $display("FAIL reset_data got instr=%h pc4=%h addr=%h want %h 0 %h", InstrD, PCPlus4D, imem_addr, NOP, RPC);
        end
        rst = 0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin
            n_err++; $display("FAIL boot_idle got req=%b want 0", imem_req);
        end
        cyc(1, 0, 0, 0, 0, 32'hAAAA_0001);
    endtask

    task automatic test_stream();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_err++; $display("FAIL stream_a0 got req=%b addr=%h want 1 00000100", imem_req, imem_addr);
        end
        cyc(1, 0, 0, 0, 0, 32'h1111_0100);
        n_cmp++; if (imem_addr !== 32'h104 || ValidD !== 1'b1 || PCPlus4D !== 32'h104 || InstrD !== 32'h1111_0100) begin
            n_err++; $display("FAIL stream_a1 got addr=%h v=%b pc4=%h instr=%h want 104 1 104 11110100", imem_addr, ValidD, PCPlus4D, InstrD);
        end
        cyc(1, 0, 0, 0, 0, 32'h1111_0104);
        n_cmp++; if (imem_addr !== 32'h108 || PCPlus4D !== 32'h108 || InstrD !== 32'h1111_0104) begin
            n_err++; $display("FAIL stream_a2 got addr=%h pc4=%h instr=%h want 108 108 11110104", imem_addr, PCPlus4D, InstrD);
        end
    endtask

    task automatic test_ready_delay();
        cyc(1, 0, 0, 1, 32'h200, 32'hDEAD_0000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 32'h0);
            n_cmp++; if (busy_pre !== 1'b1 || imem_addr !== 32'h200 || ValidD !== 1'b0 || InstrD !== NOP) begin
                n_err++; $display("FAIL delay_wait%0d got busy=%b addr=%h v=%b instr=%h want 1 200 0 0", i, busy_pre, imem_addr, ValidD, InstrD);
            end
        end
        cyc(1, 0, 0, 0, 0, 32'h2400_0200);
        n_cmp++; if (busy_pre !== 1'b0 || InstrD !== 32'h2400_0200 || PCPlus4D !== 32'h204 || ValidD !== 1'b1) begin
            n_err++; $display("FAIL delay_done got busy=%b instr=%h pc4=%h v=%b want 0 24000200 204 1", busy_pre, InstrD, PCPlus4D, ValidD);
        end
    endtask

    task automatic test_stall_hold();
        cyc(1, 1, 1, 0, 0, 32'h8C01_0004);
        n_cmp++; if (imem_req !== 1'b0 || InstrD !== 32'h2400_0200 || PCPlus4D !== 32'h204 || ValidD !== 1'b1) begin
            n_err++; $display("FAIL hold_enter got req=%b instr=%h pc4=%h v=%b want 0 24000200 204 1", imem_req, InstrD, PCPlus4D, ValidD);
        end
        cyc(0, 1, 1, 0, 0, 32'h0);
        n_cmp++; if (imem_req !== 1'b0 || InstrD !== 32'h2400_0200) begin
            n_err++; $display("FAIL hold_stay got req=%b instr=%h want 0 24000200", imem_req, InstrD);
        end
        cyc(0, 0, 0, 0, 0, 32'h0);
        n_cmp++; if (InstrD !== 32'h8C01_0004 || PCPlus4D !== 32'h208 || ValidD !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h208) begin
            n_err++; $display("FAIL hold_release got instr=%h pc4=%h v=%b req=%b addr=%h want 8c010004 208 1 1 208", InstrD, PCPlus4D, ValidD, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect();
`ifdef IF_PERF_CNT_EN
        logic [31:0] k0;
`endif
        cyc(1, 0, 0, 1, 32'h300, 32'h0);
`ifdef IF_PERF_CNT_EN
        k0 = KillCnt;
`endif
        cyc(0, 0, 0, 1, 32'h400, 32'h0);
        n_cmp++; if (ValidD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            n_err++; $display("FAIL kill_start got v=%b req=%b addr=%h want 0 1 300", ValidD, imem_req, imem_addr);
        end
        cyc(0, 0, 0, 0, 0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h300 || ValidD !== 1'b0) begin
            n_err++; $display("FAIL kill_wait got addr=%h v=%b want 300 0", imem_addr, ValidD);
        end
        cyc(1, 0, 0, 0, 0, 32'hBAD0_BAD0);
        n_cmp++; if (imem_addr !== 32'h400 || ValidD !== 1'b0 || InstrD !== NOP) begin
            n_err++; $display("FAIL kill_done got addr=%h v=%b instr=%h want 400 0 0", imem_addr, ValidD, InstrD);
        end
`ifdef IF_PERF_CNT_EN
        n_cmp++; if (KillCnt !== k0 + 32'd1) begin
            n_err++; $display("FAIL kill_cnt got %0d want %0d", KillCnt, k0 + 32'd1);
        end
`endif
    endtask

    task automatic test_redirect_stalled();
        logic v0;
        logic [31:0] i0;
        v0 = ValidD; i0 = InstrD;
        cyc(0, 0, 1, 1, 32'h500, 32'h0);
        n_cmp++; if (imem_addr !== 32'h400 || imem_req !== 1'b1 || ValidD !== v0 || InstrD !== i0) begin
            n_err++; $display("FAIL stalled_br got addr=%h req=%b v=%b instr=%h want 400 1 %b %h", imem_addr, imem_req, ValidD, InstrD, v0, i0);
        end
        cyc(1, 0, 0, 0, 0, 32'h3C00_0400);
        n_cmp++; if (imem_addr !== 32'h404 || InstrD !== 32'h3C00_0400) begin
            n_err++; $display("FAIL stalled_br_next got addr=%h instr=%h want 404 3c000400", imem_addr, InstrD);
        end
    endtask

    task automatic test_wrap();
        cyc(1, 0, 0, 1, 32'hFFFF_FFFF, 32'h0);
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_align got addr=%h want fffffffc", imem_addr);
        end
        cyc(1, 0, 0, 0, 0, 32'h0800_0000);
        n_cmp++; if (PCPlus4D !== 32'd0 || imem_addr !== 32'd0 || ValidD !== 1'b1) begin
            n_err++; $display("FAIL wrap_pc4 got pc4=%h addr=%h v=%b want 0 0 1", PCPlus4D, imem_addr, ValidD);
        end
    endtask

    task automatic test_async_reset();
        imem_ready = 0; StallF = 0; StallD = 0; PCSrcD = 0;
        #2 rst = 1;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || ValidD !== 1'b0 || ImemBusyF !== 1'b0 || imem_addr !== RPC) begin
            n_err++; $display("FAIL async_rst got req=%b v=%b busy=%b addr=%h want 0 0 0 %h", imem_req, ValidD, ImemBusyF, imem_addr, RPC);
        end
        @(posedge clk); #1;
        rst = 0;
        cyc(0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic test_random();
        logic rdy, sf, sd, br, exp_req;
        logic [31:0] t;
        for (int i = 0; i < 3000; i++) begin
            exp_req = !m_boot && !m_hold;
            n_cmp++; if (imem_req !== exp_req || (exp_req && imem_addr !== m_pc) ||
                         ValidD !== m_valid || InstrD !== m_instr || PCPlus4D !== m_pc4) begin
                n_err++; $display("FAIL rand_state@%0d got req=%b addr=%h v=%b instr=%h pc4=%h want %b %h %b %h %h",
                                  i, imem_req, imem_addr, ValidD, InstrD, PCPlus4D, exp_req, m_pc, m_valid, m_instr, m_pc4);
            end
`ifdef IF_PERF_CNT_EN
            n_cmp++; if (BubbleCnt !== m_bub || KillCnt !== m_kcnt) begin
                n_err++; $display("FAIL rand_cnt@%0d got bub=%0d kill=%0d want %0d %0d", i, BubbleCnt, KillCnt, m_bub, m_kcnt);
            end
`endif
            rdy = exp_req && ($urandom_range(0, 2) != 0);
            sf  = ($urandom_range(0, 4) == 0);
            sd  = ($urandom_range(0, 4) == 0);
            br  = ($urandom_range(0, 5) == 0);
            t   = $urandom;
            cyc(rdy, sf, sd, br, t, $urandom);
            n_cmp++; if (busy_pre !== (exp_req && !rdy)) begin
                n_err++; $display("FAIL rand_busy@%0d got %b want %b", i, busy_pre, exp_req && !rdy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ready_delay();
        test_stall_hold();
        test_redirect();
        test_redirect_stalled();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
